// File: rtl/mole_judge.sv
// Whack-a-mole round judge: latches target cells, scores keypad attempts, tracks lives.
// Define MOLE_JUDGE_STREAK_EN to award +2 per hit once three consecutive hits are banked.
module mole_judge #(
    parameter int LIVES_INIT = 3,
    parameter int SCORE_MAX  = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       round_tick,
    input  logic [3:0] position,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [8:0] led_mask,
    output logic [3:0] score_tens,
    output logic [3:0] score_ones,
    output logic [1:0] lives,
    output logic       hit_flash,
    output logic       miss_flash,
    output logic       game_over
);

    typedef enum logic [2:0] {IDLE, WAIT, ARMED, DONE, OVER} state_t;

    localparam logic [3:0] MAX_T  = 4'(SCORE_MAX / 10);
    localparam logic [3:0] MAX_O  = 4'(SCORE_MAX % 10);
    localparam logic [1:0] LIVES0 = 2'(LIVES_INIT);

    state_t     state, state_n;
    logic [3:0] target, target_n;
    logic [3:0] tens_n, ones_n;
    logic [1:0] lives_n;
    logic       hit_n, miss_n;
    logic [8:0] led_n;
    logic       over_n;

    logic       playing, tgt_live, timeout, attempt, hit, miss, lose, last_life;
    logic [1:0] lives_dec;
    logic [3:0] new_target;
    logic [7:0] score_inc;

`ifdef MOLE_JUDGE_STREAK_EN
    logic [1:0] streak, streak_n;
`endif

    // BCD +1 that holds once the score sits at the saturation value
    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        logic [7:0] r;
        r = s;
        if (s != {MAX_T, MAX_O}) begin
            if (s[3:0] == 4'd9) r = {s[7:4] + 4'd1, 4'd0};
            else                r = {s[7:4], s[3:0] + 4'd1};
        end
        return r;
    endfunction

    assign playing    = (state == WAIT) || (state == ARMED) || (state == DONE);
    assign tgt_live   = (target != 4'd0);
    assign timeout    = (state == ARMED) && round_tick && tgt_live;
    assign attempt    = (state == ARMED) && !round_tick && key_valid && tgt_live;
    assign hit        = attempt && (key_code == target);
    assign miss       = attempt && (key_code != target);
    assign lose       = timeout || miss;
    assign last_life  = (lives <= 2'd1);
    assign lives_dec  = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
    assign new_target = (position >= 4'd1 && position <= 4'd9) ? position : 4'd0;

    always_comb begin
        score_inc = bcd_inc({score_tens, score_ones});
`ifdef MOLE_JUDGE_STREAK_EN
        if (streak == 2'd3) score_inc = bcd_inc(score_inc);
`endif
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // next state
    always_comb begin
        state_n = state;
        case (state)
            IDLE, OVER: if (start) state_n = WAIT;
            WAIT:       if (round_tick) state_n = ARMED;
            ARMED: begin
                if (lose && last_life) state_n = OVER;
                else if (round_tick)   state_n = ARMED;
                else if (attempt)      state_n = DONE;
            end
            DONE:       if (round_tick) state_n = ARMED;
            default:    state_n = IDLE;
        endcase
    end

    // outputs / datapath next values
    always_comb begin
        target_n = target;
        tens_n   = score_tens;
        ones_n   = score_ones;
        lives_n  = lives;
        hit_n    = hit_flash;
        miss_n   = miss_flash;
`ifdef MOLE_JUDGE_STREAK_EN
        streak_n = streak;
`endif
        if ((state == IDLE || state == OVER) && start) begin
            target_n = 4'd0;
            tens_n   = 4'd0;
            ones_n   = 4'd0;
            lives_n  = LIVES0;
            hit_n    = 1'b0;
            miss_n   = 1'b0;
`ifdef MOLE_JUDGE_STREAK_EN
            streak_n = 2'd0;
`endif
        end else if (playing && round_tick) begin
            // old round is judged first, then the new target is taken
            hit_n  = 1'b0;
            miss_n = timeout;
            if (timeout) begin
                lives_n = lives_dec;
`ifdef MOLE_JUDGE_STREAK_EN
                streak_n = 2'd0;
`endif
            end
            if (state_n == ARMED) target_n = new_target;
        end else if (hit) begin
            {tens_n, ones_n} = score_inc;
            hit_n = 1'b1;
`ifdef MOLE_JUDGE_STREAK_EN
            streak_n = (streak == 2'd3) ? 2'd3 : streak + 2'd1;
`endif
        end else if (miss) begin
            lives_n = lives_dec;
            miss_n  = 1'b1;
`ifdef MOLE_JUDGE_STREAK_EN
            streak_n = 2'd0;
`endif
        end

        led_n  = ((state_n == ARMED || state_n == DONE) && target_n != 4'd0)
                 ? (9'b1 << (target_n - 4'd1)) : 9'b0;
        over_n = (state_n == OVER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target     <= 4'd0;
            score_tens <= 4'd0;
            score_ones <= 4'd0;
            lives      <= LIVES0;
            hit_flash  <= 1'b0;
            miss_flash <= 1'b0;
            led_mask   <= 9'b0;
            game_over  <= 1'b0;
        end else begin
            target     <= target_n;
            score_tens <= tens_n;
            score_ones <= ones_n;
            lives      <= lives_n;
            hit_flash  <= hit_n;
            miss_flash <= miss_n;
            led_mask   <= led_n;
            game_over  <= over_n;
        end
    end

`ifdef MOLE_JUDGE_STREAK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) streak <= 2'd0;
        else     streak <= streak_n;
    end
`endif

endmodule

// File: tb/tb_mole_judge.sv
// Directed bench for mole_judge: reset, hits/misses/timeouts, BCD carry/saturation, illegal targets.
module tb_mole_judge;

    logic       clk = 1'b0;
    logic       rst, start, round_tick, key_valid;
    logic [3:0] position, key_code;
    logic [8:0] led_mask;
    logic [3:0] score_tens, score_ones;
    logic [1:0] lives;
    logic       hit_flash, miss_flash, game_over;

    int checks = 0;
    int errors = 0;
    int sc  = 0;   // expected decimal score
    int stk = 0;   // expected streak (only used when the streak build is selected)

    mole_judge #(.LIVES_INIT(3), .SCORE_MAX(99)) dut (
        .clk(clk), .rst(rst), .start(start), .round_tick(round_tick),
        .position(position), .key_valid(key_valid), .key_code(key_code),
        .led_mask(led_mask), .score_tens(score_tens), .score_ones(score_ones),
        .lives(lives), .hit_flash(hit_flash), .miss_flash(miss_flash),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        start = 0; round_tick = 0; key_valid = 0;
    endtask

    task automatic tick(input int p);
        round_tick = 1; position = 4'(p);
        step();
    endtask

    task automatic key(input int k);
        key_valid = 1; key_code = 4'(k);
        step();
    endtask

    task automatic model_hit();
        int inc;
        inc = 1;
`ifdef MOLE_JUDGE_STREAK_EN
        if (stk == 3) inc = 2;
        if (stk < 3) stk++;
`endif
        sc = (sc + inc > 99) ? 99 : sc + inc;
    endtask

    task automatic round_hit(input int p);
        tick(p);
        key(p);
        model_hit();
    endtask

    task automatic chk_score(input string tag);
        chk({tag, "_tens"}, score_tens, sc / 10);
        chk({tag, "_ones"}, score_ones, sc % 10);
    endtask

    initial begin
        start = 0; round_tick = 0; key_valid = 0; position = 0; key_code = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_led", led_mask, 0);
        chk("rst_tens", score_tens, 0);
        chk("rst_ones", score_ones, 0);
        chk("rst_lives", lives, 3);
        chk("rst_hit", hit_flash, 0);
        chk("rst_miss", miss_flash, 0);
        chk("rst_over", game_over, 0);
        rst = 0;
        step();

        // round_tick ignored in IDLE
        tick(5);
        chk("idle_tick_led", led_mask, 0);

        start = 1; step();
        tick(5);
        chk("first_led", led_mask, 9'b000010000);
        chk("first_lives", lives, 3);
        chk_score("first");

        key(5); model_hit();
        chk_score("hit1");
        chk("hit1_flash", hit_flash, 1);
        key(2);
        chk_score("second_key");
        chk("second_key_miss", miss_flash, 0);
        chk("second_key_lives", lives, 3);

        // three timeouts
        tick(1);
        chk("new_round_hit_clr", hit_flash, 0);
        tick(2); stk = 0;
        chk("to1_lives", lives, 2);
        chk("to1_miss", miss_flash, 1);
        chk("to1_led", led_mask, 9'b000000010);
        tick(3);
        chk("to2_lives", lives, 1);
        tick(4);
        chk("to3_lives", lives, 0);
        chk("to3_over", game_over, 1);
        chk("to3_led", led_mask, 0);

        // start + round_tick together from OVER: start wins, lands in WAIT
        start = 1; round_tick = 1; position = 6;
        step(); sc = 0; stk = 0;
        chk("restart_lives", lives, 3);
        chk_score("restart");
        chk("restart_over", game_over, 0);
        chk("restart_led", led_mask, 0);
        chk("restart_miss", miss_flash, 0);

        // wrong key in first round
        tick(9);
        chk("wait_to_armed_led", led_mask, 9'b100000000);
        key(4);
        chk("wrong_key_lives", lives, 2);
        chk("wrong_key_miss", miss_flash, 1);
        chk("wrong_key_hit", hit_flash, 0);

        // BCD carry 09 -> 10
        for (int i = 0; i < 40 && sc < 9; i++) round_hit((i % 9) + 1);
        chk_score("at09");
        round_hit(3);
        chk_score("carry");
        for (int i = 0; i < 200 && sc < 99; i++) round_hit((i % 9) + 1);
        chk_score("at99");
        round_hit(8);
        chk_score("sat99");
        chk("sat99_flash", hit_flash, 1);

        // round_tick and key in the same cycle: key dropped, old round times out
        tick(7);
        round_tick = 1; position = 3; key_valid = 1; key_code = 7;
        step(); stk = 0;
        chk("coll_lives", lives, 1);
        chk("coll_miss", miss_flash, 1);
        chk("coll_hit", hit_flash, 0);
        chk("coll_led", led_mask, 9'b000000100);
        chk_score("coll");

        // illegal target: no key effect, no timeout
        key(3); model_hit();
        tick(0);
        chk("ill_led", led_mask, 0);
        chk("ill_hit", hit_flash, 0);
        key(1);
        chk("ill_key_lives", lives, 1);
        chk("ill_key_miss", miss_flash, 0);
        chk("ill_key_hit", hit_flash, 0);
        tick(4);
        chk("ill_no_timeout_lives", lives, 1);
        chk("ill_no_timeout_miss", miss_flash, 0);
        chk("ill_next_led", led_mask, 9'b000001000);
        tick(12);
        chk("ill12_lives", lives, 0);
        chk("ill12_over", game_over, 1);

        // restart, then illegal 12 followed by a tick must not cost a life
        start = 1; step(); sc = 0; stk = 0;
        tick(12);
        chk("pos12_led", led_mask, 0);
        tick(2);
        chk("pos12_lives", lives, 3);
        chk("pos12_led2", led_mask, 9'b000000010);
        key(2); model_hit();
        chk_score("pre_rst");

        // asynchronous reset mid-round
        #2 rst = 1;
        #1;
        chk("arst_led", led_mask, 0);
        chk("arst_ones", score_ones, 0);
        chk("arst_lives", lives, 3);
        chk("arst_hit", hit_flash, 0);
        chk("arst_over", game_over, 0);
        rst = 0;
        step();
        tick(5);
        chk("arst_idle_led", led_mask, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
